// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank write-port arbiter.
// Imported by the arbiter top and its scoreboard.
package regbank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard for registers awaiting a long-latency result.
// Set on issue, cleared on commit; hazard reads registered bits only.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] chk0_addr,
    input  logic [ADDR_W-1:0] chk1_addr,
    output logic              hazard
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        // NOTE: default first so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_addr] = 1'b0;
        // Applied after the clear so a same-cycle issue to the same register wins.
        if (set_en && (set_addr != ADDR_W'(REG_ZERO)))
            busy_d[set_addr] = 1'b1;
    end

    // NOTE: the busy bits are control state, not data storage, so they get the reset.
    always_ff @(posedge CLK) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign hazard = busy_q[chk0_addr] | busy_q[chk1_addr];

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the register bank's single write port between pipeline writeback (A)
// and a long-latency unit (B), forcing a one-cycle writeback stall to bound B's wait.
module regbank_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              a_wEn,
    input  logic [ADDR_W-1:0] a_wAddr,
    input  logic [DATA_W-1:0] a_wData,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_wAddr,
    input  logic [DATA_W-1:0] b_wData,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] chk0_addr,
    input  logic [ADDR_W-1:0] chk1_addr,
    output logic              hazard,
    output logic              pipe_stall,
    output logic              wEn,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       grant_a, grant_b;

    // Write-port grant and mux: A always wins, B takes an otherwise idle port.
    always_comb begin
        grant_a = a_wEn & ~reset;
        grant_b = b_valid & ~a_wEn & ~reset;
        if (grant_b) begin
            wAddr = b_wAddr;
            wData = b_wData;
        end else begin
            wAddr = a_wAddr;
            wData = a_wData;
        end
        wEn = (grant_a | grant_b) && (wAddr != ADDR_W'(REG_ZERO));
    end

    assign b_ready = grant_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (b_valid && a_wEn) begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
            WAIT: begin
                // Either B got the port or it withdrew; both end the wait.
                if (!b_valid || !a_wEn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = FORCE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FORCE: begin
                if (!b_valid || !a_wEn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pipe_stall = (state_q == FORCE);

    regbank_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .CLK       (CLK),
        .reset     (reset),
        .set_en    (iss_en),
        .set_addr  (iss_addr),
        .clr_en    (grant_b),
        .clr_addr  (b_wAddr),
        .chk0_addr (chk0_addr),
        .chk1_addr (chk1_addr),
        .hazard    (hazard)
    );

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: write mux, register-0 drop, scoreboard,
// starvation bound and reset out of FORCE, with hand-computed expectations.
module tb_regbank_wb_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        a_wEn;
    logic [4:0]  a_wAddr;
    logic [31:0] a_wData;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wAddr;
    logic [31:0] b_wData;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  chk0_addr;
    logic [4:0]  chk1_addr;
    logic        hazard;
    logic        pipe_stall;
    logic        wEn;
    logic [4:0]  wAddr;
    logic [31:0] wData;

    int checks = 0;
    int errors = 0;

    regbank_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (4)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .a_wEn      (a_wEn),
        .a_wAddr    (a_wAddr),
        .a_wData    (a_wData),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_wAddr    (b_wAddr),
        .b_wData    (b_wData),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .chk0_addr  (chk0_addr),
        .chk1_addr  (chk1_addr),
        .hazard     (hazard),
        .pipe_stall (pipe_stall),
        .wEn        (wEn),
        .wAddr      (wAddr),
        .wData      (wData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // A and B both request from IDLE: four blocked cycles, then FORCE on the fifth.
    task automatic starve(input string tag);
        a_wEn   = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check({tag, "_stall_lo"}, pipe_stall, 1'b0);
            check({tag, "_b_blocked"}, b_ready, 1'b0);
            next_cycle();
        end
        #1;
        check({tag, "_stall_hi"}, pipe_stall, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        a_wEn     = 1'b1;
        a_wAddr   = 5'd5;
        a_wData   = 32'h0;
        b_valid   = 1'b1;
        b_wAddr   = 5'd9;
        b_wData   = 32'h0;
        iss_en    = 1'b0;
        iss_addr  = 5'd0;
        chk0_addr = 5'd0;
        chk1_addr = 5'd0;
        #2;
        check("rst_wEn", wEn, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        next_cycle();
        reset   = 1'b0;
        a_wEn   = 1'b0;
        b_valid = 1'b0;
        #1;
        check("rst_stall", pipe_stall, 1'b0);
        check("rst_hazard", hazard, 1'b0);

        // A only
        next_cycle();
        a_wEn   = 1'b1;
        a_wAddr = 5'd5;
        a_wData = 32'hDEADBEEF;
        #1;
        check("a_wEn", wEn, 1'b1);
        check("a_wAddr", wAddr, 5'd5);
        check("a_wData", wData, 32'hDEADBEEF);
        check("a_b_ready", b_ready, 1'b0);
        next_cycle();
        a_wEn = 1'b0;
        #1;
        check("a_stall", pipe_stall, 1'b0);
        check("a_idle_wEn", wEn, 1'b0);

        // B on an idle port, clearing a pending register 9
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        next_cycle();
        iss_en    = 1'b0;
        chk0_addr = 5'd9;
        #1;
        check("b_hazard_set", hazard, 1'b1);
        b_valid = 1'b1;
        b_wAddr = 5'd9;
        b_wData = 32'h0000_1234;
        #1;
        check("b_ready", b_ready, 1'b1);
        check("b_wEn", wEn, 1'b1);
        check("b_wAddr", wAddr, 5'd9);
        check("b_wData", wData, 32'h0000_1234);
        check("b_no_bypass", hazard, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        #1;
        check("b_hazard_clr", hazard, 1'b0);

        // Scoreboard: issue 12 at c0, commit at c3
        iss_en    = 1'b1;
        iss_addr  = 5'd12;
        chk0_addr = 5'd12;
        #1;
        check("sb_c0", hazard, 1'b0);
        next_cycle();
        iss_en = 1'b0;
        #1;
        check("sb_c1", hazard, 1'b1);
        next_cycle();
        chk0_addr = 5'd0;
        chk1_addr = 5'd12;
        #1;
        check("sb_c2_chk1", hazard, 1'b1);
        next_cycle();
        b_valid = 1'b1;
        b_wAddr = 5'd12;
        #1;
        check("sb_c3_commit", b_ready, 1'b1);
        check("sb_c3", hazard, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        #1;
        check("sb_c4", hazard, 1'b0);

        // Issue and commit to 12 together: set wins
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        b_valid  = 1'b1;
        b_wAddr  = 5'd12;
        next_cycle();
        iss_en  = 1'b0;
        b_valid = 1'b0;
        #1;
        check("sb_set_wins", hazard, 1'b1);
        b_valid = 1'b1;
        next_cycle();
        b_valid = 1'b0;
        chk1_addr = 5'd0;
        #1;
        check("sb_cleanup", hazard, 1'b0);

        // Register 0
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        next_cycle();
        iss_en  = 1'b0;
        #1;
        check("r0_busy", hazard, 1'b0);
        a_wEn   = 1'b1;
        a_wAddr = 5'd0;
        #1;
        check("r0_a_wEn", wEn, 1'b0);
        a_wEn   = 1'b0;
        b_valid = 1'b1;
        b_wAddr = 5'd0;
        #1;
        check("r0_b_ready", b_ready, 1'b1);
        check("r0_b_wEn", wEn, 1'b0);
        next_cycle();
        b_valid = 1'b0;

        // Starvation bound, A released in FORCE
        a_wAddr = 5'd3;
        a_wData = 32'hA5A5_0003;
        b_wAddr = 5'd7;
        b_wData = 32'h7777_0007;
        next_cycle();
        starve("starve");
        a_wEn = 1'b0;
        #1;
        check("starve_b_ready", b_ready, 1'b1);
        check("starve_wAddr", wAddr, 5'd7);
        check("starve_wData", wData, 32'h7777_0007);
        next_cycle();
        b_valid = 1'b0;
        #1;
        check("starve_c5_stall", pipe_stall, 1'b0);

        // B withdraws mid-WAIT: the count must restart from scratch
        a_wEn   = 1'b1;
        b_valid = 1'b1;
        next_cycle();
        next_cycle();
        b_valid = 1'b0;
        next_cycle();
        starve("restart");
        a_wEn = 1'b0;
        next_cycle();
        b_valid = 1'b0;
        #1;
        check("restart_exit", pipe_stall, 1'b0);

        // Reset mid-FORCE with a pending register 20
        iss_en   = 1'b1;
        iss_addr = 5'd20;
        next_cycle();
        iss_en    = 1'b0;
        chk0_addr = 5'd20;
        starve("force");
        #1;
        check("force_a_wins", b_ready, 1'b0);
        check("force_a_wAddr", wAddr, 5'd3);
        check("force_a_hazard", hazard, 1'b1);
        next_cycle();
        check("force_hold", pipe_stall, 1'b1);
        reset = 1'b1;
        #1;
        check("force_rst_wEn", wEn, 1'b0);
        check("force_rst_b_ready", b_ready, 1'b0);
        next_cycle();
        reset   = 1'b0;
        a_wEn   = 1'b0;
        b_valid = 1'b0;
        #1;
        check("post_rst_stall", pipe_stall, 1'b0);
        check("post_rst_busy", hazard, 1'b0);
        next_cycle();
        starve("post_rst");
        a_wEn = 1'b0;
        #1;
        check("post_rst_grant", b_ready, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        #1;
        check("post_rst_idle", pipe_stall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
